mul_seq: RTL and testbench

MUL_SEQ -- requirements
Module: mul_seq

---
 rtl/mul_seq.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_mul_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// Sequential RV-style multiplier: MUL/MULH/MULHSU/MULHU on top of an unsigned
// shift-add core, with a single-entry operand cache and a one-cycle sign correction.

module mul_seq_core #(
  parameter int A_W = 32,
  parameter int B_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stb,
  input  logic                 is_signed,
  input  logic [A_W-1:0]       a,
  input  logic [B_W-1:0]       b,
  output logic                 ack,
  output logic [A_W+B_W-1:0]   p
);
  localparam int PW = A_W + B_W;
  localparam int CW = $clog2(B_W + 1);

  logic          busy_r;
  logic          neg_r;
  logic          ack_r;
  logic [CW-1:0] cnt_r;
  logic [PW-1:0] mcand_r;
  logic [PW-1:0] acc_r;
  logic [PW-1:0] p_r;
  logic [B_W-1:0] mplier_r;
  logic [PW-1:0] sum_s;
  logic [A_W-1:0] a_mag_s;
  logic [B_W-1:0] b_mag_s;
  logic          neg_s;

  // Operand magnitudes for signed mode and the per-step partial sum.
  always_comb begin
    neg_s = is_signed && (a[A_W-1] ^ b[B_W-1]);
    if (is_signed && a[A_W-1]) begin
      a_mag_s = -a;
    end else begin
      a_mag_s = a;
    end
    if (is_signed && b[B_W-1]) begin
      b_mag_s = -b;
    end else begin
      b_mag_s = b;
    end
    if (mplier_r[0]) begin
      sum_s = acc_r + mcand_r;
    end else begin
      sum_s = acc_r;
    end
  end

  // One multiplier bit per cycle; ack pulses for one cycle with p valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r   <= 1'b0;
      neg_r    <= 1'b0;
      ack_r    <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      mcand_r  <= {PW{1'b0}};
      acc_r    <= {PW{1'b0}};
      p_r      <= {PW{1'b0}};
      mplier_r <= {B_W{1'b0}};
    end else begin
      ack_r <= 1'b0;
      if (busy_r) begin
        acc_r    <= sum_s;
        mcand_r  <= {mcand_r[PW-2:0], 1'b0};
        mplier_r <= {1'b0, mplier_r[B_W-1:1]};
        cnt_r    <= cnt_r - CW'(1);
        if (cnt_r == CW'(1)) begin
          busy_r <= 1'b0;
          ack_r  <= 1'b1;
          p_r    <= neg_r ? -sum_s : sum_s;
        end
      end else if (stb) begin
        busy_r   <= 1'b1;
        cnt_r    <= CW'(B_W);
        mcand_r  <= {{B_W{1'b0}}, a_mag_s};
        mplier_r <= b_mag_s;
        acc_r    <= {PW{1'b0}};
        neg_r    <= neg_s;
      end
    end
  end

  assign ack = ack_r;
  assign p   = p_r;
endmodule

module mul_seq #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_data,
  output logic [TAG_W-1:0] resp_tag
);
  localparam int PW = 2 * XLEN;
  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BUSY  = 3'd1,
    ST_CORR  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [XLEN-1:0]  a_r;
  logic [XLEN-1:0]  b_r;
  logic [1:0]       op_r;
  logic [TAG_W-1:0] tag_r;
  logic [XLEN-1:0]  a_last_r;
  logic [XLEN-1:0]  b_last_r;
  logic             cache_valid_r;
  logic [PW-1:0]    prod_r;
  logic             stb_r;
  logic [XLEN-1:0]  resp_data_r;
  logic [TAG_W-1:0] resp_tag_r;

  logic             ack_s;
  logic [PW-1:0]    p_s;
  logic             accept_s;
  logic             hit_s;
  logic             capture_s;
  logic [XLEN-1:0]  hi_s;
  logic [XLEN-1:0]  lo_s;
  logic [XLEN-1:0]  corr_a_s;
  logic [XLEN-1:0]  corr_b_s;
  logic [XLEN-1:0]  result_s;

  mul_seq_core #(
    .A_W (XLEN),
    .B_W (XLEN)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .stb       (stb_r),
    .is_signed (1'b0),
    .a         (a_r),
    .b         (b_r),
    .ack       (ack_s),
    .p         (p_s)
  );

  assign req_ready  = (state_r == ST_IDLE) && !flush;
  assign resp_valid = (state_r == ST_RESP);
  assign resp_data  = resp_data_r;
  assign resp_tag   = resp_tag_r;

  assign accept_s  = req_valid && req_ready;
  assign hit_s     = cache_valid_r && (req_a == a_last_r) && (req_b == b_last_r);
  // A drained product is still worth keeping for a later repeat of the operands.
  assign capture_s = ack_s && ((state_r == ST_BUSY) || (state_r == ST_DRAIN));

  // Signed high words recovered from the unsigned product by subtracting the sign terms.
  always_comb begin
    hi_s = prod_r[PW-1:XLEN];
    lo_s = prod_r[XLEN-1:0];
    if (a_r[XLEN-1]) begin
      corr_a_s = b_r;
    end else begin
      corr_a_s = {XLEN{1'b0}};
    end
    if (b_r[XLEN-1]) begin
      corr_b_s = a_r;
    end else begin
      corr_b_s = {XLEN{1'b0}};
    end
    case (op_r)
      OP_MUL:    result_s = lo_s;
      OP_MULH:   result_s = hi_s - corr_a_s - corr_b_s;
      OP_MULHSU: result_s = hi_s - corr_a_s;
      OP_MULHU:  result_s = hi_s;
      default:   result_s = lo_s;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && hit_s) begin
          state_s = ST_CORR;
        end else if (accept_s) begin
          state_s = ST_BUSY;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (flush && ack_s) begin
          state_s = ST_IDLE;
        end else if (flush) begin
          state_s = ST_DRAIN;
        end else if (ack_s) begin
          state_s = ST_CORR;
        end else begin
          state_s = ST_BUSY;
        end
      end
      ST_CORR: begin
        if (flush) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      ST_RESP: begin
        if (flush || resp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      ST_DRAIN: begin
        if (ack_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request latch, product cache, core strobe and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r           <= {XLEN{1'b0}};
      b_r           <= {XLEN{1'b0}};
      op_r          <= 2'b00;
      tag_r         <= {TAG_W{1'b0}};
      a_last_r      <= {XLEN{1'b0}};
      b_last_r      <= {XLEN{1'b0}};
      cache_valid_r <= 1'b0;
      prod_r        <= {PW{1'b0}};
      stb_r         <= 1'b0;
      resp_data_r   <= {XLEN{1'b0}};
      resp_tag_r    <= {TAG_W{1'b0}};
    end else begin
      stb_r <= accept_s && !hit_s;
      if (accept_s) begin
        a_r   <= req_a;
        b_r   <= req_b;
        op_r  <= req_op;
        tag_r <= req_tag;
      end
      if (capture_s) begin
        prod_r        <= p_s;
        a_last_r      <= a_r;
        b_last_r      <= b_r;
        cache_valid_r <= 1'b1;
      end
      if ((state_r == ST_CORR) && !flush) begin
        resp_data_r <= result_s;
        resp_tag_r  <= tag_r;
      end
    end
  end
endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: directed corner cases followed by random
// requests, all compared against a plain 64-bit arithmetic reference.

module tb_mul_seq;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_op = 2'b00;
  logic [XLEN-1:0]  req_a = '0;
  logic [XLEN-1:0]  req_b = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             flush = 1'b0;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic [XLEN-1:0]  resp_data;
  logic [TAG_W-1:0] resp_tag;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stb_cnt = 0;
  int ack_cyc = -1000;

  logic            model_valid = 1'b0;
  logic [XLEN-1:0] model_a = '0;
  logic [XLEN-1:0] model_b = '0;

  mul_seq #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_tag    (req_tag),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_tag   (resp_tag)
  );

  always #5 clk = ~clk;

  // Cycle index plus observation of the core strobe and completion pulse.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dut.stb_r) stb_cnt <= stb_cnt + 1;
    if (dut.ack_s) ack_cyc <= cyc;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ua, ub, sa, sb, p;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      2'b00:   begin p = ua * ub; return p[31:0]; end
      2'b01:   begin p = sa * sb; return p[63:32]; end
      2'b10:   begin p = sa * ub; return p[63:32]; end
      default: begin p = ua * ub; return p[63:32]; end
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, check hit/miss behaviour, latency, result, then consume it.
  task automatic run_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input int hold);
    logic hit;
    logic [31:0] exp_d;
    int acc_cyc, stb0, t;
    hit = model_valid && (a == model_a) && (b == model_b);
    exp_d = ref_res(op, a, b);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    t = 0;
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    check("accept_ready", 64'(req_ready), 64'(1));
    acc_cyc = cyc;
    stb0 = stb_cnt;
    @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while (!resp_valid && t < 200) begin @(negedge clk); t++; end
    check("resp_seen", 64'(resp_valid), 64'(1));
    check("stb_pulses", 64'(stb_cnt - stb0), hit ? 64'(0) : 64'(1));
    if (hit) check("hit_latency", 64'(cyc - acc_cyc), 64'(2));
    else     check("miss_latency", 64'(cyc - ack_cyc), 64'(2));
    if (!hit) begin model_valid = 1'b1; model_a = a; model_b = b; end
    check("resp_data", 64'(resp_data), 64'(exp_d));
    check("resp_tag", 64'(resp_tag), 64'(tag));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(resp_valid), 64'(1));
      check("hold_data", 64'(resp_data), 64'(exp_d));
      check("hold_tag", 64'(resp_tag), 64'(tag));
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_consumed", 64'(resp_valid), 64'(0));
  endtask

  initial begin
    int t, first_rdy, acc_cyc;
    logic saw_v;
    logic [31:0] ra, rb;
    logic [31:0] corners [5];
    corners[0] = 32'h0; corners[1] = 32'h1; corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000; corners[4] = 32'h7FFF_FFFF;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(resp_valid), 64'(0));
    check("rst_data", 64'(resp_data), 64'(0));
    check("rst_tag", 64'(resp_tag), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(req_ready), 64'(1));
    check("post_rst_valid", 64'(resp_valid), 64'(0));

    run_req(2'b00, 32'd7, 32'd6, 5'd3, 0);
    check("mul_7x6_is_42", 64'(resp_data), 64'(42));
    run_req(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 0);
    run_req(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 0);
    run_req(2'b10, 32'hFFFF_FFFF, 32'd2, 5'd6, 0);
    run_req(2'b10, 32'd2, 32'hFFFF_FFFF, 5'd7, 0);
    run_req(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd8, 0);
    run_req(2'b00, 32'h8000_0000, 32'h8000_0000, 5'd9, 5);

    // Flush in BUSY: no response, ready returns one cycle after the core completes.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00; req_a = 32'h1234; req_b = 32'h5678; req_tag = 5'd10;
    @(negedge clk);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    saw_v = 1'b0; first_rdy = -1; t = 0;
    while (first_rdy < 0 && t < 100) begin
      if (resp_valid) saw_v = 1'b1;
      if (req_ready) first_rdy = cyc;
      else begin @(negedge clk); t++; end
    end
    resp_ready = 1'b0;
    check("flush_no_resp", 64'(saw_v), 64'(0));
    check("flush_ready_after_ack", 64'(first_rdy - ack_cyc), 64'(1));
    model_valid = 1'b1; model_a = 32'h1234; model_b = 32'h5678;
    run_req(2'b11, 32'h0001_0000, 32'h0001_0000, 5'd11, 0);

    // Flush in RESP, with a concurrent request that must not be taken.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b11; req_a = 32'h0001_0000; req_b = 32'h0001_0000; req_tag = 5'd12;
    @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while (!resp_valid && t < 10) begin @(negedge clk); t++; end
    check("rflush_resp_seen", 64'(resp_valid), 64'(1));
    flush = 1'b1; req_valid = 1'b1;
    @(negedge clk);
    check("rflush_valid_dropped", 64'(resp_valid), 64'(0));
    check("rflush_ready_low", 64'(req_ready), 64'(0));
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("rflush_not_accepted", 64'(req_ready), 64'(1));

    // Reset mid-BUSY forgets the operands.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00; req_a = 32'd3; req_b = 32'd5; req_tag = 5'd13;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", 64'(resp_valid), 64'(0));
    check("midrst_data", 64'(resp_data), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    model_valid = 1'b0;
    @(negedge clk);
    check("midrst_ready", 64'(req_ready), 64'(1));
    run_req(2'b00, 32'd3, 32'd5, 5'd14, 0);
    check("mul_3x5_is_15", 64'(resp_data), 64'(15));

    // Randomized requests with occasional operand reuse and corner operands.
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0: begin ra = model_a; rb = model_b; end
        1: begin ra = corners[$urandom_range(0, 4)]; rb = corners[$urandom_range(0, 4)]; end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      run_req(2'($urandom_range(0, 3)), ra, rb, 5'($urandom_range(0, 31)),
              int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
